mov_seq: RTL and testbench



---
 rtl/mov_seq.sv | 189 ++++++++++++++++++
 tb/tb_mov_seq.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mov_seq.sv
`default_nettype none
// ============================================================================
//  Module   : mov_seq
//  Purpose  : Register-move sequencer (MOV / MOVI / XCH) driving register-file
//             read/write strobes with a configurable read latency.
//  Revision : 1.0 - initial release
// ============================================================================
module mov_seq #(
    parameter int          DATA_W  = 8,
    parameter int          ADDR_W  = 4,
    parameter int          RD_LAT  = 1,
    parameter logic [3:0]  OP_MOVI = 4'd9,
    parameter logic [3:0]  OP_MOV  = 4'd10,
    parameter logic [3:0]  OP_XCH  = 4'd11
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MOVstr,
    input  logic [3:0]        opCode,
    input  logic [ADDR_W-1:0] regI,
    input  logic [ADDR_W-1:0] regJ,
    input  logic [DATA_W-1:0] imm,
    input  logic [DATA_W-1:0] rdData,
    output logic              RrEn,
    output logic [ADDR_W-1:0] rAddr,
    output logic              RwEn,
    output logic [ADDR_W-1:0] wAddr,
    output logic [DATA_W-1:0] wData,
    output logic              busy,
    output logic              IF,
    output logic              err
);

    localparam int                CNT_W    = $clog2(RD_LAT + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(RD_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD1  = 3'd1,
        S_W1   = 3'd2,
        S_RD2  = 3'd3,
        S_W2   = 3'd4,
        S_WR1  = 3'd5,
        S_WR2  = 3'd6,
        S_DONE = 3'd7
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic [3:0]         op_q,    op_d;
    logic [ADDR_W-1:0]  i_q,     i_d;
    logic [ADDR_W-1:0]  j_q,     j_d;
    logic [DATA_W-1:0]  imm_q,   imm_d;
    logic [DATA_W-1:0]  ta_q,    ta_d;
    logic [DATA_W-1:0]  tb_q,    tb_d;
    logic               ill_q,   ill_d;
    logic [ADDR_W-1:0]  raddr_q, raddr_d;
    logic [ADDR_W-1:0]  waddr_q, waddr_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            i_q     <= '0;
            j_q     <= '0;
            imm_q   <= '0;
            ta_q    <= '0;
            tb_q    <= '0;
            ill_q   <= 1'b0;
            raddr_q <= '0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            i_q     <= i_d;
            j_q     <= j_d;
            imm_q   <= imm_d;
            ta_q    <= ta_d;
            tb_q    <= tb_d;
            ill_q   <= ill_d;
            raddr_q <= raddr_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        i_d     = i_q;
        j_d     = j_q;
        imm_d   = imm_q;
        ta_d    = ta_q;
        tb_d    = tb_q;
        ill_d   = ill_q;
        case (state_q)
            S_IDLE: begin
                if (MOVstr) begin
                    op_d  = opCode;
                    i_d   = regI;
                    j_d   = regJ;
                    imm_d = imm;
                    ill_d = 1'b0;
                    cnt_d = '0;
                    if (opCode == OP_MOVI) begin
                        state_d = S_WR1;
                    end else if (opCode == OP_MOV || opCode == OP_XCH) begin
                        state_d = S_RD1;
                    end else begin
                        state_d = S_DONE;
                        ill_d   = 1'b1;
                    end
                end
            end
            S_RD1: begin
                state_d = S_W1;
                cnt_d   = '0;
            end
            // Read data is only guaranteed in the final wait cycle
            S_W1: begin
                if (cnt_q == CNT_LAST) begin
                    ta_d    = rdData;
                    state_d = (op_q == OP_XCH) ? S_RD2 : S_WR1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_RD2: begin
                state_d = S_W2;
                cnt_d   = '0;
            end
            S_W2: begin
                if (cnt_q == CNT_LAST) begin
                    tb_d    = rdData;
                    state_d = S_WR1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_WR1:   state_d = (op_q == OP_XCH) ? S_WR2 : S_DONE;
            S_WR2:   state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Addresses and write data hold their last driven value between accesses
    always_comb begin
        RrEn  = 1'b0;
        RwEn  = 1'b0;
        rAddr = raddr_q;
        wAddr = waddr_q;
        wData = wdata_q;
        busy  = (state_q != S_IDLE);
        IF    = (state_q == S_DONE);
        err   = (state_q == S_DONE) && ill_q;
        case (state_q)
            S_RD1: begin
                RrEn  = 1'b1;
                rAddr = j_q;
            end
            S_RD2: begin
                RrEn  = 1'b1;
                rAddr = i_q;
            end
            S_WR1: begin
                RwEn  = 1'b1;
                wAddr = i_q;
                wData = (op_q == OP_MOVI) ? imm_q : ta_q;
            end
            S_WR2: begin
                RwEn  = 1'b1;
                wAddr = j_q;
                wData = tb_q;
            end
            default: ;
        endcase
        raddr_d = rAddr;
        waddr_d = wAddr;
        wdata_d = wData;
    end

endmodule
`default_nettype wire

// File: tb/tb_mov_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mov_seq
//  Purpose  : Cycle-accurate scoreboard bench for mov_seq at RD_LAT=1 and 3.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mov_seq;

    localparam logic [3:0] OPI = 4'd9;
    localparam logic [3:0] OPM = 4'd10;
    localparam logic [3:0] OPX = 4'd11;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       movstr1 = 1'b0, movstr3 = 1'b0;
    logic [3:0] op = '0, ri = '0, rj = '0;
    logic [7:0] imm = '0;
    logic [7:0] rd1, rd3;

    logic       rr1, rw1, busy1, if1, err1;
    logic [3:0] ra1, wa1;
    logic [7:0] wd1;
    logic       rr3, rw3, busy3, if3, err3;
    logic [3:0] ra3, wa3;
    logic [7:0] wd3;

    always #5 clk = ~clk;

    mov_seq #(.RD_LAT(1)) dut1 (
        .clk(clk), .reset(reset), .MOVstr(movstr1), .opCode(op), .regI(ri),
        .regJ(rj), .imm(imm), .rdData(rd1), .RrEn(rr1), .rAddr(ra1),
        .RwEn(rw1), .wAddr(wa1), .wData(wd1), .busy(busy1), .IF(if1), .err(err1)
    );

    mov_seq #(.RD_LAT(3)) dut3 (
        .clk(clk), .reset(reset), .MOVstr(movstr3), .opCode(op), .regI(ri),
        .regJ(rj), .imm(imm), .rdData(rd3), .RrEn(rr3), .rAddr(ra3),
        .RwEn(rw3), .wAddr(wa3), .wData(wd3), .busy(busy3), .IF(if3), .err(err3)
    );

    // Register-file models: data is valid only in the exact RD_LAT-th cycle
    logic [7:0] rf1 [16];
    logic [7:0] rf3 [16];
    logic       ld_en = 1'b0, ld_sel = 1'b0;
    logic [3:0] ld_a = '0;
    logic [7:0] ld_d = '0;
    logic       pv1 = 1'b0;
    logic [3:0] pa1 = '0;
    logic [2:0] pv3 = '0;
    logic [3:0] pa3 [3];

    always @(posedge clk) begin
        pv1    <= rr1;
        pa1    <= ra1;
        pv3    <= {pv3[1:0], rr3};
        pa3[0] <= ra3;
        pa3[1] <= pa3[0];
        pa3[2] <= pa3[1];
        if (ld_en && !ld_sel) rf1[ld_a] <= ld_d;
        else if (rw1)         rf1[wa1]  <= wd1;
        if (ld_en && ld_sel)  rf3[ld_a] <= ld_d;
        else if (rw3)         rf3[wa3]  <= wd3;
    end

    assign rd1 = pv1    ? rf1[pa1]    : 8'hEE;
    assign rd3 = pv3[2] ? rf3[pa3[2]] : 8'hEE;

    typedef struct packed {
        logic       rr;
        logic [3:0] ra;
        logic       rw;
        logic [3:0] wa;
        logic [7:0] wd;
        logic       busy;
        logic       fin;
        logic       err;
    } cyc_t;

    typedef struct {
        int         s;
        logic [3:0] o;
        logic [3:0] i;
        logic [3:0] j;
        logic [7:0] im;
        logic [7:0] vi;
        logic [7:0] vj;
    } vec_t;

    cyc_t       q1[$];
    cyc_t       q3[$];
    logic [3:0] hr [2];
    logic [3:0] hw [2];
    logic [7:0] hd [2];
    int         checks = 0;
    int         fails = 0;
    bit         mon_en = 1'b0;

    function automatic cyc_t idle_rec(input int s);
        cyc_t c;
        c      = '0;
        c.ra   = hr[s];
        c.wa   = hw[s];
        c.wd   = hd[s];
        return c;
    endfunction

    function automatic cyc_t base(input int s);
        cyc_t c;
        c      = idle_rec(s);
        c.busy = 1'b1;
        return c;
    endfunction

    function automatic void push(input int s, input cyc_t c);
        if (s == 0) q1.push_back(c);
        else        q3.push_back(c);
    endfunction

    function automatic void exp_rd(input int s, input logic [3:0] a, input int lat);
        cyc_t c;
        hr[s] = a;
        c     = base(s);
        c.rr  = 1'b1;
        push(s, c);
        for (int k = 0; k < lat; k++) push(s, base(s));
    endfunction

    function automatic void exp_wr(input int s, input logic [3:0] a, input logic [7:0] d);
        cyc_t c;
        hw[s] = a;
        hd[s] = d;
        c     = base(s);
        c.rw  = 1'b1;
        push(s, c);
    endfunction

    function automatic void exp_done(input int s, input logic e);
        cyc_t c;
        c     = base(s);
        c.fin = 1'b1;
        c.err = e;
        push(s, c);
    endfunction

    // Expected trace from the start cycle (cycle 0) through the IF cycle
    function automatic void gen(input int s, input logic [3:0] o, input logic [3:0] i,
                                input logic [3:0] j, input logic [7:0] im,
                                input logic [7:0] vi, input logic [7:0] vj);
        int lat;
        lat = (s != 0) ? 3 : 1;
        push(s, idle_rec(s));
        case (o)
            OPI: begin
                exp_wr(s, i, im);
                exp_done(s, 1'b0);
            end
            OPM: begin
                exp_rd(s, j, lat);
                exp_wr(s, i, vj);
                exp_done(s, 1'b0);
            end
            OPX: begin
                exp_rd(s, j, lat);
                exp_rd(s, i, lat);
                exp_wr(s, i, vj);
                exp_wr(s, j, vi);
                exp_done(s, 1'b0);
            end
            default: exp_done(s, 1'b1);
        endcase
    endfunction

    task automatic check_dut(input int s, input cyc_t act);
        cyc_t ex;
        if (s == 0 && q1.size() > 0)      ex = q1.pop_front();
        else if (s == 1 && q3.size() > 0) ex = q3.pop_front();
        else                              ex = idle_rec(s);
        checks++;
        if (act !== ex) begin
            fails++;
            $display("FAIL cycle_dut_lat%0d t=%0t got rr=%b ra=%h rw=%b wa=%h wd=%h busy=%b if=%b err=%b want rr=%b ra=%h rw=%b wa=%h wd=%h busy=%b if=%b err=%b",
                     (s != 0) ? 3 : 1, $time,
                     act.rr, act.ra, act.rw, act.wa, act.wd, act.busy, act.fin, act.err,
                     ex.rr, ex.ra, ex.rw, ex.wa, ex.wd, ex.busy, ex.fin, ex.err);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            check_dut(0, {rr1, ra1, rw1, wa1, wd1, busy1, if1, err1});
            check_dut(1, {rr3, ra3, rw3, wa3, wd3, busy3, if3, err3});
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input int s, input logic [3:0] a, input logic [7:0] d);
        ld_en  = 1'b1;
        ld_sel = (s != 0);
        ld_a   = a;
        ld_d   = d;
        tick();
        ld_en  = 1'b0;
    endtask

    task automatic drain;
        int n;
        n = 0;
        while ((q1.size() > 0 || q3.size() > 0) && n < 60) begin
            tick();
            n++;
        end
        if (q1.size() > 0 || q3.size() > 0) begin
            checks++;
            fails++;
            $display("FAIL drain_timeout got q1=%0d q3=%0d pending, want 0", q1.size(), q3.size());
            q1.delete();
            q3.delete();
        end
        tick();
    endtask

    task automatic run(input vec_t v);
        preload(v.s, v.i, v.vi);
        preload(v.s, v.j, v.vj);
        op  = v.o;
        ri  = v.i;
        rj  = v.j;
        imm = v.im;
        if (v.s != 0) movstr3 = 1'b1;
        else          movstr1 = 1'b1;
        gen(v.s, v.o, v.i, v.j, v.im, v.vi, v.vj);
        tick();
        movstr1 = 1'b0;
        movstr3 = 1'b0;
        drain();
    endtask

    vec_t tv [10];

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        tv[0] = '{0, OPI, 4'd3,  4'd0,  8'hA5, 8'h00, 8'h00};
        tv[1] = '{0, OPM, 4'd2,  4'd7,  8'h00, 8'h00, 8'h3C};
        tv[2] = '{1, OPM, 4'd2,  4'd7,  8'h00, 8'h00, 8'h3C};
        tv[3] = '{0, OPX, 4'd1,  4'd4,  8'h00, 8'h11, 8'h44};
        tv[4] = '{1, OPX, 4'd5,  4'd9,  8'h00, 8'h5A, 8'hC3};
        tv[5] = '{0, 4'd0, 4'd0, 4'd0,  8'h00, 8'h00, 8'h00};
        tv[6] = '{0, 4'd15, 4'd8, 4'd2, 8'h99, 8'h00, 8'h00};
        tv[7] = '{0, OPX, 4'd6,  4'd6,  8'h00, 8'h77, 8'h77};
        tv[8] = '{1, OPI, 4'd15, 4'd1,  8'hFF, 8'h00, 8'h00};
        tv[9] = '{0, OPM, 4'd0,  4'd15, 8'h00, 8'h12, 8'hB4};
        for (int s = 0; s < 2; s++) begin
            hr[s] = '0;
            hw[s] = '0;
            hd[s] = '0;
        end

        reset = 1'b1;
        repeat (3) tick();
        reset  = 1'b0;
        mon_en = 1'b1;
        tick();

        for (int k = 0; k < 10; k++) run(tv[k]);

        // Start held high across a MOV while inputs change mid-operation
        preload(0, 4'd7, 8'h3C);
        op = OPM; ri = 4'd2; rj = 4'd7; imm = 8'h00;
        movstr1 = 1'b1;
        gen(0, OPM, 4'd2, 4'd7, 8'h00, 8'h00, 8'h3C);
        tick();
        op = OPI; ri = 4'd5; imm = 8'h77;
        gen(0, OPI, 4'd5, 4'd7, 8'h77, 8'h00, 8'h00);
        repeat (5) tick();
        movstr1 = 1'b0;
        drain();

        // Reset in the W1 cycle of a MOV, then a clean MOVI
        op = OPM; ri = 4'd2; rj = 4'd7; imm = 8'h00;
        movstr1 = 1'b1;
        gen(0, OPM, 4'd2, 4'd7, 8'h00, 8'h00, 8'h3C);
        tick();
        movstr1 = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        q1.delete();
        for (int s = 0; s < 2; s++) begin
            hr[s] = '0;
            hw[s] = '0;
            hd[s] = '0;
        end
        repeat (4) tick();
        run('{0, OPI, 4'd12, 4'd0, 8'h5C, 8'h00, 8'h00});

        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
`default_nettype wire
